muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_datapath.sv | 99 +++++++++
 rtl/muldiv_unit.sv | 87 ++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    ADJUST = 2'b10
  } state_e;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic signedOp);
    return (signedOp && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator pair shared by shift-add multiply and restoring divide, plus final sign fix.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic [31:0] resultHi,
  output logic [31:0] resultLo
);

  op_e         opReg;
  logic [31:0] operand;
  logic [31:0] accHi;
  logic [31:0] accLo;
  logic [31:0] rawA;
  logic        negMain;
  logic        negRem;
  logic        divZero;

  logic        loadSigned;
  logic [31:0] absA;
  logic [31:0] absB;
  logic        isDiv;
  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic        divBit;
  logic [31:0] divRem;
  logic [63:0] product;

  always_comb begin
    loadSigned = isSignedOp(op);
    absA       = magnitude(operandA, loadSigned);
    absB       = magnitude(operandB, loadSigned);
    isDiv      = (opReg == OP_DIV) || (opReg == OP_DIVU);
    mulSum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    divShift   = {accHi, accLo[31]};
    divBit     = (divShift >= {1'b0, operand});
    divRem     = divBit ? (divShift[31:0] - operand) : divShift[31:0];
  end

  // Multiply: accHi:accLo is the 64-bit product shifting right, multiplier in accLo.
  // Divide: accHi is the partial remainder, accLo shifts dividend out and quotient in.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      opReg   <= OP_MULT;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      rawA    <= '0;
      negMain <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (load) begin
      opReg   <= op_e'(op);
      rawA    <= operandA;
      negMain <= loadSigned & (operandA[31] ^ operandB[31]);
      negRem  <= loadSigned & operandA[31];
      divZero <= (operandB == '0);
      accHi   <= '0;
      if (op[1]) begin
        operand <= absB;
        accLo   <= absA;
      end else begin
        operand <= absA;
        accLo   <= absB;
      end
    end else if (step) begin
      if (isDiv) begin
        accHi <= divRem;
        accLo <= {accLo[30:0], divBit};
      end else begin
        accHi <= mulSum[32:1];
        accLo <= {mulSum[0], accLo[31:1]};
      end
    end
  end

  // Divide by zero bypasses sign fix so Hi returns the original dividend bits.
  always_comb begin
    product  = {accHi, accLo};
    resultHi = '0;
    resultLo = '0;
    if (!isDiv) begin
      {resultHi, resultLo} = negMain ? -product : product;
    end else if (divZero) begin
      resultHi = rawA;
      resultLo = '1;
    end else begin
      resultLo = negMain ? -accLo : accLo;
      resultHi = negRem ? -accHi : accHi;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: FSM, iteration counter and architectural HI/LO registers.
module muldiv_unit #(
  parameter int unsigned ITER = muldiv_pkg::ITER
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  import muldiv_pkg::*;

  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             step;
  logic [31:0]      resultHi;
  logic [31:0]      resultLo;

  always_comb begin
    load = (state == IDLE) && Start;
    step = (state == CALC);
  end

  muldiv_datapath datapath (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .load     (load),
    .step     (step),
    .op       (Op),
    .operandA (OperandA),
    .operandB (OperandB),
    .resultHi (resultHi),
    .resultLo (resultLo)
  );

  // Start takes priority over MTHI/MTLO in IDLE; strobes are dropped while busy.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            state <= CALC;
            count <= '0;
            Busy  <= 1'b1;
          end else begin
            if (HiWrite) Hi <= WriteData;
            if (LoWrite) Lo <= WriteData;
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == LAST) state <= ADJUST;
        end
        ADJUST: begin
          Hi    <= resultHi;
          Lo    <= resultLo;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus directed literal cases.
module tb_muldiv_unit;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OperandA = '0;
  logic [31:0] OperandB = '0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.ITER(32)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .HiWrite   (HiWrite),
    .LoWrite   (LoWrite),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {Hi, Lo} as the architecture defines them.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          sp;
    logic [31:0]     q;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 2'b00) begin
      sp = sa * sb;
      return 64'(sp);
    end
    if (op == 2'b01) return ua * ub;
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (op == 2'b10) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = 32'(ua / ub);
      r = 32'(ua % ub);
    end
    return {r, q};
  endfunction

  logic        mBusy = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic [63:0] mPend = '0;
  int          mLeft = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mBusy = 1'b0;
      mDone = 1'b0;
      mHi   = '0;
      mLo   = '0;
      mLeft = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          {mHi, mLo} = mPend;
        end
      end else if (Start) begin
        mBusy = 1'b1;
        mLeft = 33;
        mPend = refResult(Op, OperandA, OperandB);
      end else begin
        if (HiWrite) mHi = WriteData;
        if (LoWrite) mLo = WriteData;
      end
    end
  end

  always @(negedge Clock) begin
    check("busy", Busy, mBusy);
    check("done", Done, mDone);
    check("hi", Hi, mHi);
    check("lo", Lo, mLo);
  end

  // Issues an op at the current negedge; optionally disturbs with Start+writes at cycle disturbAt.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input int disturbAt);
    int lat;
    int busyCnt;
    bit seen;
    Op = op;
    OperandA = a;
    OperandB = b;
    Start = 1'b1;
    lat = 0;
    busyCnt = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge Clock);
      Start = 1'b0;
      HiWrite = 1'b0;
      LoWrite = 1'b0;
      lat++;
      if (Busy) busyCnt++;
      if (Done) seen = 1'b1;
      if (lat == disturbAt) begin
        Start = 1'b1;
        Op = 2'b11;
        OperandA = 32'h00000009;
        OperandB = 32'h00000002;
        HiWrite = 1'b1;
        LoWrite = 1'b1;
        WriteData = 32'hDEADBEEF;
      end
    end
    check({name, " latency"}, lat, 34);
    check({name, " busyCycles"}, busyCnt, 33);
    check({name, " Hi"}, Hi, expHi);
    check({name, " Lo"}, Lo, expLo);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int doneCount;
    int waitCnt;
    repeat (2) @(negedge Clock);
    check("reset Hi", Hi, 32'h0);
    check("reset Lo", Lo, 32'h0);
    check("reset Busy", Busy, 1'b0);
    check("reset Done", Done, 1'b0);
    #2 Reset_n = 1'b1;
    @(negedge Clock);

    runOp("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    runOp("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    runOp("div -7/2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    runOp("div overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    runOp("div 7/-2", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    runOp("divu by zero", 2'b11, 32'd100, 32'h0, 32'h00000064, 32'hFFFFFFFF, 0);
    runOp("div by zero", 2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0);
    runOp("divu 1000/7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 0);

    HiWrite = 1'b1;
    WriteData = 32'h12345678;
    @(negedge Clock);
    HiWrite = 1'b0;
    check("mthi Hi", Hi, 32'h12345678);
    check("mthi Lo kept", Lo, 32'd142);
    HiWrite = 1'b1;
    LoWrite = 1'b1;
    WriteData = 32'hA5A5A5A5;
    @(negedge Clock);
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    check("mthilo Hi", Hi, 32'hA5A5A5A5);
    check("mthilo Lo", Lo, 32'hA5A5A5A5);

    HiWrite = 1'b1;
    WriteData = 32'hCAFEF00D;
    runOp("start wins", 2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1);
    runOp("busy ignore", 2'b00, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);

    Op = 2'b01;
    OperandA = 32'h00010000;
    OperandB = 32'h00010000;
    Start = 1'b1;
    repeat (10) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    #2 Reset_n = 1'b0;
    @(negedge Clock);
    check("abort Hi", Hi, 32'h0);
    check("abort Lo", Lo, 32'h0);
    check("abort Busy", Busy, 1'b0);
    #2 Reset_n = 1'b1;
    doneCount = 0;
    repeat (40) begin
      @(negedge Clock);
      if (Done) doneCount++;
    end
    check("abort no Done", doneCount, 0);

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge Clock);
      Start = ($urandom_range(0, 3) == 0);
      Op = 2'($urandom_range(0, 3));
      OperandA = pickVal();
      OperandB = ($urandom_range(0, 7) == 0) ? 32'h0 : pickVal();
      HiWrite = ($urandom_range(0, 5) == 0);
      LoWrite = ($urandom_range(0, 5) == 0);
      WriteData = $urandom;
    end
    @(negedge Clock);
    Start = 1'b0;
    HiWrite = 1'b0;
    LoWrite = 1'b0;
    waitCnt = 0;
    while (Busy && waitCnt < 60) begin
      @(negedge Clock);
      waitCnt++;
    end
    check("final idle", Busy, 1'b0);
    repeat (2) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
